// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution window generator:
// default geometry, counter widths, window index mapping and window count.
package conv_pkg;

    localparam int KERNEL_DEF = 3;
    localparam int N_DEF      = 4;
    localparam int IMG_W_DEF  = 8;
    localparam int IMG_H_DEF  = 8;

    // A counter for a depth-1 range still needs a one-bit register.
    function automatic int cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int idx(input int r, input int c, input int kernel);
        return r * kernel + c;
    endfunction

    function automatic int win_count(input int kernel, input int img_w, input int img_h);
        return (img_h - kernel + 1) * (img_w - kernel + 1);
    endfunction

    localparam int COL_W     = cnt_w(IMG_W_DEF);
    localparam int ROW_W     = cnt_w(IMG_H_DEF);
    localparam int WIN_COUNT = win_count(KERNEL_DEF, IMG_W_DEF, IMG_H_DEF);

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-stream input and packed-window output bundle of the window generator.
// master = the window generator, slave = pixel source / window consumer.
interface conv_window_gen_if #(
    parameter int KERNEL = 3,
    parameter int N      = 4
);
    logic [N-1:0]               pix_in;
    logic                       pix_valid;
    logic                       sof_in;
    logic [KERNEL*KERNEL*N-1:0] data2conv;
    logic                       en_out;
    logic                       frame_done;

    modport master (
        input  pix_in, pix_valid, sof_in,
        output data2conv, en_out, frame_done
    );

    modport slave (
        output pix_in, pix_valid, sof_in,
        input  data2conv, en_out, frame_done
    );
endinterface

// File: rtl/conv_line_buffer.sv
// One image row of pixel delay addressed by column; the read is combinational
// so the old pixel at a column is available in the same cycle it is replaced.
module conv_line_buffer #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end
endmodule

// File: rtl/conv_window_gen.sv
// Sliding KERNEL x KERNEL window generator over a raster pixel stream.
// Optional macro CONVWIN_STRIDE2_EN: emit only every second window in both axes.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int KERNEL = KERNEL_DEF,
    parameter int N      = N_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_gen_if.master   win_if
);
    localparam int   C_W     = cnt_w(IMG_W);
    localparam int   R_W     = cnt_w(IMG_H);
    localparam int   WIN_E   = KERNEL * KERNEL;
    localparam logic KM1_ODD = 1'((KERNEL - 1) % 2);

    logic [C_W-1:0] col_reg, col_next, eff_col;
    logic [R_W-1:0] row_reg, row_next, eff_row;
    logic           accept;
    logic           stride_ok;
    logic           en_reg, en_next;
    logic           frame_done_reg, frame_done_next;
    logic [N-1:0]   col_vec  [KERNEL];
    logic [N-1:0]   win_reg  [WIN_E];
    logic [N-1:0]   win_next [WIN_E];

    assign accept  = win_if.pix_valid;
    // A start-of-frame pixel is taken as (0,0) regardless of where the counters are.
    assign eff_col = win_if.sof_in ? '0 : col_reg;
    assign eff_row = win_if.sof_in ? '0 : row_reg;

    // Line buffer gi holds the row gi+1 above the incoming one; they form a cascade.
    genvar gi;
    for (gi = 0; gi < KERNEL - 1; gi++) begin : g_lb
        logic [N-1:0] wr_data;
        if (gi == 0) begin : g_head
            assign wr_data = win_if.pix_in;
        end else begin : g_chain
            assign wr_data = col_vec[KERNEL-1-gi];
        end
        conv_line_buffer #(
            .DEPTH  (IMG_W),
            .WIDTH  (N),
            .ADDR_W (C_W)
        ) u_lb (
            .clk     (clk),
            .we      (accept),
            .addr    (eff_col),
            .wr_data (wr_data),
            .rd_data (col_vec[KERNEL-2-gi])
        );
    end
    assign col_vec[KERNEL-1] = win_if.pix_in;

`ifdef CONVWIN_STRIDE2_EN
    assign stride_ok = (eff_row[0] == KM1_ODD) && (eff_col[0] == KM1_ODD);
`else
    assign stride_ok = 1'b1;
`endif

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (eff_col == C_W'(IMG_W - 1)) begin
                col_next = '0;
                row_next = (eff_row == R_W'(IMG_H - 1)) ? '0 : eff_row + R_W'(1);
            end else begin
                col_next = eff_col + C_W'(1);
                row_next = eff_row;
            end
        end
    end

    always_comb begin
        en_next = accept && stride_ok
                  && (eff_row >= R_W'(KERNEL - 1))
                  && (eff_col >= C_W'(KERNEL - 1));
        frame_done_next = accept
                  && (eff_row == R_W'(IMG_H - 1))
                  && (eff_col == C_W'(IMG_W - 1));
    end

    // Window slides left by one column; the new column enters on the right.
    always_comb begin
        win_next = win_reg;
        if (accept) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_next[idx(r, c, KERNEL)] = win_reg[idx(r, c + 1, KERNEL)];
                end
                win_next[idx(r, KERNEL - 1, KERNEL)] = col_vec[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg        <= '0;
            row_reg        <= '0;
            en_reg         <= 1'b0;
            frame_done_reg <= 1'b0;
            for (int i = 0; i < WIN_E; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            en_reg         <= en_next;
            frame_done_reg <= frame_done_next;
            win_reg        <= win_next;
        end
    end

    for (gi = 0; gi < WIN_E; gi++) begin : g_pack
        assign win_if.data2conv[gi*N +: N] = win_reg[gi];
    end
    assign win_if.en_out     = en_reg;
    assign win_if.frame_done = frame_done_reg;
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen (KERNEL=3, N=8, 8x8 ramp image);
// honours CONVWIN_STRIDE2_EN when the build defines it.
module tb_conv_window_gen;
    localparam int K     = 3;
    localparam int NB    = 8;
    localparam int W     = 8;
    localparam int H     = 8;
    localparam int WIN_W = K * K * NB;
`ifdef CONVWIN_STRIDE2_EN
    localparam int FRAME_WIN = 9;
`else
    localparam int FRAME_WIN = 36;
`endif

    typedef struct {
        int               cyc;
        bit               en;
        bit               fd;
        logic [WIN_W-1:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    int   fd_cnt = 0;
    int   exp_en_cnt = 0;

    exp_t             sb[$];
    logic [WIN_W-1:0] got_win[$];
    logic [WIN_W-1:0] t1_win[$];

    conv_window_gen_if #(.KERNEL(K), .N(NB)) bus();

    conv_window_gen #(
        .KERNEL (K),
        .N      (NB),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .win_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] ramp(input int r, input int c);
        return NB'(r * 8 + c);
    endfunction

    function automatic bit en_exp(input int r, input int c);
        bit e;
        e = (r >= K - 1) && (c >= K - 1);
`ifdef CONVWIN_STRIDE2_EN
        e = e && ((r - (K - 1)) % 2 == 0) && ((c - (K - 1)) % 2 == 0);
`endif
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.sof_in    = 1'b0;
        end
    endtask

    // Drives one pixel at logical position (r,c), optionally preceded by idle cycles.
    task automatic send(input int r, input int c, input bit sof, input int idle_pct);
        exp_t e;
        while ($urandom_range(99) < idle_pct) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.pix_in    = NB'($urandom);
            bus.sof_in    = 1'($urandom_range(1));
        end
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_in    = ramp(r, c);
        bus.sof_in    = sof;
        e.en  = en_exp(r, c);
        e.fd  = (r == H - 1) && (c == W - 1);
        e.cyc = cyc + 1;
        e.win = '0;
        if (e.en) begin
            exp_en_cnt++;
            for (int rr = 0; rr < K; rr++)
                for (int cc = 0; cc < K; cc++)
                    e.win[(rr*K + cc)*NB +: NB] = ramp(r - (K - 1) + rr, c - (K - 1) + cc);
        end
        if (e.en || e.fd) sb.push_back(e);
    endtask

    task automatic send_frame(input bit sof, input int idle_pct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(r, c, sof && (r == 0) && (c == 0), idle_pct);
    endtask

    task automatic clear_counts();
        en_cnt = 0;
        fd_cnt = 0;
        exp_en_cnt = 0;
        got_win.delete();
    endtask

    task automatic end_section(input string tag);
        idle(4);
        chk({tag, "_en_model"}, en_cnt, exp_en_cnt);
        chk({tag, "_sb_left"}, sb.size(), 0);
    endtask

    // Output monitor: every en_out/frame_done pulse must match the next expectation.
    always @(negedge clk) begin
        if (!rst && (bus.en_out || bus.frame_done)) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {bus.en_out, bus.frame_done}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("en_out", bus.en_out, e.en);
                chk("frame_done", bus.frame_done, e.fd);
                if (e.en) chk("window", bus.data2conv, e.win);
            end
            if (bus.en_out) begin
                en_cnt++;
                got_win.push_back(bus.data2conv);
            end
            if (bus.frame_done) fd_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NB-1:0] first_exp [K*K];
        logic [WIN_W-1:0] w;
        first_exp = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};

        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.sof_in    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data2conv", bus.data2conv, 0);
        chk("rst_en_out", bus.en_out, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        rst = 1'b0;

        // Continuous frame with sof on the first pixel.
        clear_counts();
        send_frame(1'b1, 0);
        end_section("s1");
        chk("s1_en_count", en_cnt, FRAME_WIN);
        chk("s1_fd_count", fd_cnt, 1);
        if (got_win.size() >= 4) begin
            w = got_win[0];
            for (int i = 0; i < K*K; i++)
                chk($sformatf("s1_w0_e%0d", i), w[i*NB +: NB], first_exp[i]);
`ifdef CONVWIN_STRIDE2_EN
            w = got_win[1];
            chk("s1_w1_e0", w[NB-1:0], 8'd2);
            w = got_win[3];
            chk("s1_w3_e0", w[NB-1:0], 8'd16);
`else
            w = got_win[got_win.size()-1];
            chk("s1_last_e8", w[8*NB +: NB], 8'd63);
`endif
        end
        t1_win = got_win;

        // Same frame with random idle cycles (and stray sof while idle).
        clear_counts();
        send_frame(1'b1, 40);
        end_section("s2");
        chk("s2_en_count", en_cnt, FRAME_WIN);
        for (int i = 0; i < got_win.size() && i < t1_win.size(); i++)
            chk($sformatf("s2_same_w%0d", i), got_win[i], t1_win[i]);

        // Two back-to-back frames.
        clear_counts();
        send_frame(1'b1, 0);
        send_frame(1'b1, 0);
        end_section("s3");
        chk("s3_en_count", en_cnt, 2 * FRAME_WIN);
        chk("s3_fd_count", fd_cnt, 2);
        if (got_win.size() > FRAME_WIN && t1_win.size() > 0)
            chk("s3_f2_first", got_win[FRAME_WIN], t1_win[0]);

        // Partial frame up to (4,2), then sof lands where the counters read (4,3).
        clear_counts();
        for (int r = 0; r <= 4; r++)
            for (int c = 0; c < W; c++)
                if (r < 4 || c < 3) send(r, c, 1'b0, 0);
        send_frame(1'b1, 0);
        end_section("s4");
        chk("s4_fd_count", fd_cnt, 1);

        // Asynchronous reset while the window at (5,5) is on the outputs.
        clear_counts();
        for (int r = 0; r <= 5; r++)
            for (int c = 0; c < W; c++)
                if (r < 5 || c <= 5) send(r, c, 1'b0, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_en", bus.en_out, en_exp(5, 5));
        rst = 1'b1;
        bus.pix_valid = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_data2conv", bus.data2conv, 0);
        chk("async_rst_en_out", bus.en_out, 0);
        chk("async_rst_frame_done", bus.frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        send_frame(1'b0, 0);
        end_section("s5");
        chk("s5_en_count", en_cnt, FRAME_WIN);
        chk("s5_fd_count", fd_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
